alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Issues a byte-stream of operation requests into the two-stage ALU and drives its stage-1 and stage-2 control lines with the correct pipeline alignment. Chains addition carry across multi-byte packets, including when issue has bubbles. Captures the ALU result and carry into an output FIFO with a valid/ready interface. Backpressure is credit-based because the ALU pipeline cannot stall.

Parameters:
DEPTH, 4, response FIFO entries (power of 2, >= 2); also the credit limit for in-flight plus queued bytes.

Ports:
CLK  in  1  system clock, rising edge.
RESET_BAR  in  1  asynchronous, active-low reset.
REQ_VALID  in  1  request byte valid.
REQ_READY  out  1  sequencer accepts the byte at this edge.
REQ_LHS  in  8  LHS operand byte.
REQ_RHS  in  8  RHS operand byte.
REQ_SHIFT_OP  in  2  ALU SHIFT_OP for this byte.
REQ_SHIFT_INTERP  in  2  ALU SHIFT_INTERP for this byte.
REQ_LOGIC_OP  in  4  ALU LOGIC_OP for this byte.
REQ_CIN  in  1  carry-in for the first byte of a packet; ignored on later bytes.
REQ_LAST  in  1  last byte of packet (LSB first).
ALU_LHS, ALU_RHS  out  8 each  to ALU LHS/RHS.
ALU_SHIFT_OP, ALU_SHIFT_INTERP  out  2 each  to ALU.
ALU_LOGIC_OP  out  4  to ALU.
ALU_CARRY_SEL  out  2  to ALU CARRY_SEL.
ALU_RESULT  in  8  from ALU RESULT.
ALU_CARRY_OUT  in  1  from ALU CARRY_OUT.
RSP_VALID  out  1  FIFO not empty.
RSP_READY  in  1  consumer pops at this edge.
RSP_RESULT  out  8  result byte.
RSP_CARRY  out  1  carry out of this byte.
RSP_LAST  out  1  copied from REQ_LAST.

Behaviour:
- Reset, asynchronous: all ALU_* outputs 0; ALU_CARRY_SEL=00; v_s1=v_s2=0; FIFO empty; RSP_VALID=0; state=IDLE; saved carry=0. REQ_READY=1 after reset release.
- Reset mid-packet discards all in-flight and queued bytes. The next accepted byte starts a new packet.
- Issue: a handshake at edge e0 registers the ALU_* operand and stage-1 control outputs. These are valid in cycle S1 = the cycle after e0, with v_s1=1.
- When no byte is accepted, ALU_* operand and control outputs hold their previous values and v_s1=0.
- Stage 2: in cycle S2 = S1+1, v_s2=1 and ALU_CARRY_SEL is driven for that byte. Otherwise ALU_CARRY_SEL=00.
- At the end of S2, ALU_RESULT and ALU_CARRY_OUT are pushed into the FIFO with LAST. RSP_VALID rises in the cycle after that push (3 cycles after the e0 cycle).
- ALU_CARRY_SEL for a stage-2 byte:
  - First byte of packet: {1'b0, REQ_CIN}, i.e. 00 or 01.
  - Chained byte whose predecessor was in stage 2 on the immediately preceding cycle: 10.
  - Chained byte after a bubble: {1'b0, saved_carry}. saved_carry is ALU_CARRY_OUT captured at the end of every valid stage-2 cycle.
- State machine, advanced on each handshake:
  - IDLE -> CHAIN on accept with REQ_LAST=0.
  - CHAIN -> IDLE on accept with REQ_LAST=1.
  - A first-byte flag travels with each byte through S1/S2.
- Credits: occ = fifo_count + v_s1 + v_s2; REQ_READY = (occ < DEPTH).
  - A pop in the same cycle is not credited, so REQ_READY does not depend on RSP_READY.
  - Guarantees no FIFO overflow.
- FIFO: push and pop in the same cycle keep count unchanged. A pop when empty is ignored. Pointers wrap modulo DEPTH.
- Throughput: 1 byte/cycle when RSP_READY=1 continuously.

Optional Feature:
ALU_SEQ_STATS_EN
- Defined: adds outputs STAT_BYTES[15:0] and STAT_STALLS[15:0], both reset to 0 and saturating at 0xFFFF.
  - STAT_BYTES counts accepted bytes.
  - STAT_STALLS counts cycles with REQ_VALID=1 and REQ_READY=0.
- Undefined: neither port nor counter exists.
- Core behaviour is identical in both cases.

Test Plan:
1. 16-bit add 0x12FF+0x0001 as 2 back-to-back bytes, identity shift, RHS-pass logic op, REQ_CIN=0 -> ALU_CARRY_SEL 00 then 10; responses {0x00, C=1, LAST=0}, {0x13, C=0, LAST=1}.
2. Same packet with REQ_VALID low for 2 cycles between bytes -> high byte stage 2 drives CARRY_SEL=01; same responses as scenario 1.
3. Single byte 0x00+0x00, REQ_CIN=1 -> CARRY_SEL=01; response {0x01, C=0}; RSP_VALID rises exactly 3 cycles after the handshake cycle.
4. RSP_READY=0, REQ_VALID held with 6 single-byte requests -> exactly 4 accepted, then REQ_READY=0. After RSP_READY=1, all 6 responses arrive in order with none lost or duplicated.
5. Assert RESET_BAR low while byte 1 of a 3-byte packet is in S1 -> all outputs at reset values, RSP_VALID=0. A fresh 1-byte packet with REQ_CIN=0 uses CARRY_SEL=00.
6. With ALU_SEQ_STATS_EN defined, run scenario 4 -> STAT_BYTES=6, and STAT_STALLS equals the number of cycles REQ_READY was low while REQ_VALID was high.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request, ALU drive/return and response signal bundle for alu_sequencer
//
// Purpose: groups the handshake and bus signals around the sequencer.
//   REQ_*  request byte stream into the sequencer (valid/ready)
//   ALU_*  operand/control drive to the two-stage ALU and its result return
//   RSP_*  response byte stream out of the sequencer FIFO (valid/ready)
// Modports:
//   slave  : the sequencer side
//   master : the environment side (request producer, ALU, response consumer)
interface alu_sequencer_if;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [7:0] REQ_LHS;
    logic [7:0] REQ_RHS;
    logic [1:0] REQ_SHIFT_OP;
    logic [1:0] REQ_SHIFT_INTERP;
    logic [3:0] REQ_LOGIC_OP;
    logic       REQ_CIN;
    logic       REQ_LAST;

    logic [7:0] ALU_LHS;
    logic [7:0] ALU_RHS;
    logic [1:0] ALU_SHIFT_OP;
    logic [1:0] ALU_SHIFT_INTERP;
    logic [3:0] ALU_LOGIC_OP;
    logic [1:0] ALU_CARRY_SEL;
    logic [7:0] ALU_RESULT;
    logic       ALU_CARRY_OUT;

    logic       RSP_VALID;
    logic       RSP_READY;
    logic [7:0] RSP_RESULT;
    logic       RSP_CARRY;
    logic       RSP_LAST;

    modport slave (
        input  REQ_VALID, REQ_LHS, REQ_RHS, REQ_SHIFT_OP, REQ_SHIFT_INTERP, REQ_LOGIC_OP, REQ_CIN, REQ_LAST,
        output REQ_READY,
        output ALU_LHS, ALU_RHS, ALU_SHIFT_OP, ALU_SHIFT_INTERP, ALU_LOGIC_OP, ALU_CARRY_SEL,
        input  ALU_RESULT, ALU_CARRY_OUT,
        output RSP_VALID, RSP_RESULT, RSP_CARRY, RSP_LAST,
        input  RSP_READY
    );

    modport master (
        output REQ_VALID, REQ_LHS, REQ_RHS, REQ_SHIFT_OP, REQ_SHIFT_INTERP, REQ_LOGIC_OP, REQ_CIN, REQ_LAST,
        input  REQ_READY,
        input  ALU_LHS, ALU_RHS, ALU_SHIFT_OP, ALU_SHIFT_INTERP, ALU_LOGIC_OP, ALU_CARRY_SEL,
        output ALU_RESULT, ALU_CARRY_OUT,
        input  RSP_VALID, RSP_RESULT, RSP_CARRY, RSP_LAST,
        output RSP_READY
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issues byte requests into a two-stage ALU and queues its results
//
// Purpose: accepts request bytes, registers them onto the ALU stage-1 inputs, drives
// ALU_CARRY_SEL in stage 2 so addition carry chains across multi-byte packets (with or
// without issue bubbles), and captures result/carry into a response FIFO. The ALU cannot
// stall, so requests are admitted only while in-flight plus queued bytes fit the FIFO.
// Ports:
//   CLK         system clock, rising edge
//   RESET_BAR   asynchronous active-low reset
//   bus         alu_sequencer_if.slave (REQ_* in, ALU_* drive/return, RSP_* out)
//   STAT_BYTES  accepted-byte counter, saturating (only with ALU_SEQ_STATS_EN)
//   STAT_STALLS cycles with REQ_VALID=1 and REQ_READY=0, saturating (only with ALU_SEQ_STATS_EN)
// Parameter: DEPTH - response FIFO entries (power of 2, >= 2) and credit limit
// Optional feature macro: ALU_SEQ_STATS_EN
module alu_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic           CLK,
    input  logic           RESET_BAR,
    alu_sequencer_if.slave bus
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]    STAT_BYTES,
    output logic [15:0]    STAT_STALLS
`endif
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [CW:0] OCC_LIMIT = (CW + 1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        CHAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          req_ready;
    logic          accept;
    logic          first_byte;

    logic          v_s1_q, first_s1_q, cin_s1_q, last_s1_q;
    logic          v_s2_q, first_s2_q, cin_s2_q, last_s2_q;
    logic          prev_s2_q;
    logic          saved_carry_q;

    logic [7:0]    lhs_q, rhs_q;
    logic [1:0]    shift_op_q, shift_interp_q;
    logic [3:0]    logic_op_q;
    logic [1:0]    carry_sel;

    logic [9:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW:0]   occ;
    logic          push, pop;

    // A pop in the same cycle is deliberately not credited, keeping REQ_READY
    // independent of RSP_READY.
    assign occ       = {1'b0, count_q} + {{CW{1'b0}}, v_s1_q} + {{CW{1'b0}}, v_s2_q};
    assign req_ready = (occ < OCC_LIMIT);
    assign accept    = bus.REQ_VALID && req_ready;
    assign push      = v_s2_q;
    assign pop       = bus.RSP_READY && (count_q != '0);

    always_ff @(posedge CLK or negedge RESET_BAR) begin
        if (!RESET_BAR) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        first_byte = (state_q == IDLE);
        if (accept) begin
            state_d = bus.REQ_LAST ? IDLE : CHAIN;
        end
    end

    // Stage tracking: the first-byte flag, packet carry-in and LAST travel with each byte.
    always_ff @(posedge CLK or negedge RESET_BAR) begin
        if (!RESET_BAR) begin
            v_s1_q        <= 1'b0;
            first_s1_q    <= 1'b0;
            cin_s1_q      <= 1'b0;
            last_s1_q     <= 1'b0;
            v_s2_q        <= 1'b0;
            first_s2_q    <= 1'b0;
            cin_s2_q      <= 1'b0;
            last_s2_q     <= 1'b0;
            prev_s2_q     <= 1'b0;
            saved_carry_q <= 1'b0;
        end else begin
            v_s1_q <= accept;
            if (accept) begin
                first_s1_q <= first_byte;
                cin_s1_q   <= bus.REQ_CIN;
                last_s1_q  <= bus.REQ_LAST;
            end
            v_s2_q     <= v_s1_q;
            first_s2_q <= first_s1_q;
            cin_s2_q   <= cin_s1_q;
            last_s2_q  <= last_s1_q;
            prev_s2_q  <= v_s2_q;
            if (v_s2_q) begin
                saved_carry_q <= bus.ALU_CARRY_OUT;
            end
        end
    end

    // Operand and stage-1 control registers hold their value between accepted bytes.
    always_ff @(posedge CLK or negedge RESET_BAR) begin
        if (!RESET_BAR) begin
            lhs_q          <= 8'h00;
            rhs_q          <= 8'h00;
            shift_op_q     <= 2'b00;
            shift_interp_q <= 2'b00;
            logic_op_q     <= 4'h0;
        end else if (accept) begin
            lhs_q          <= bus.REQ_LHS;
            rhs_q          <= bus.REQ_RHS;
            shift_op_q     <= bus.REQ_SHIFT_OP;
            shift_interp_q <= bus.REQ_SHIFT_INTERP;
            logic_op_q     <= bus.REQ_LOGIC_OP;
        end
    end

    // Chained bytes use the ALU's own carry (10) only when the predecessor was in
    // stage 2 on the previous cycle; after a bubble that carry is gone, so the
    // saved copy is fed back as an explicit carry-in.
    always_comb begin
        carry_sel = 2'b00;
        if (v_s2_q) begin
            if (first_s2_q) begin
                carry_sel = {1'b0, cin_s2_q};
            end else if (prev_s2_q) begin
                carry_sel = 2'b10;
            end else begin
                carry_sel = {1'b0, saved_carry_q};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {last_s2_q, bus.ALU_CARRY_OUT, bus.ALU_RESULT};
        end
    end

    always_ff @(posedge CLK or negedge RESET_BAR) begin
        if (!RESET_BAR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.REQ_READY        = req_ready;
    assign bus.ALU_LHS          = lhs_q;
    assign bus.ALU_RHS          = rhs_q;
    assign bus.ALU_SHIFT_OP     = shift_op_q;
    assign bus.ALU_SHIFT_INTERP = shift_interp_q;
    assign bus.ALU_LOGIC_OP     = logic_op_q;
    assign bus.ALU_CARRY_SEL    = carry_sel;
    assign bus.RSP_VALID        = (count_q != '0);
    assign {bus.RSP_LAST, bus.RSP_CARRY, bus.RSP_RESULT} = fifo_mem[rd_ptr_q];

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_bytes_q, stat_stalls_q;

    always_ff @(posedge CLK or negedge RESET_BAR) begin
        if (!RESET_BAR) begin
            stat_bytes_q  <= 16'h0000;
            stat_stalls_q <= 16'h0000;
        end else begin
            if (accept && (stat_bytes_q != 16'hFFFF)) begin
                stat_bytes_q <= stat_bytes_q + 16'd1;
            end
            if (bus.REQ_VALID && !req_ready && (stat_stalls_q != 16'hFFFF)) begin
                stat_stalls_q <= stat_stalls_q + 16'd1;
            end
        end
    end

    assign STAT_BYTES  = stat_bytes_q;
    assign STAT_STALLS = stat_stalls_q;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a two-stage adder ALU model
module tb_alu_sequencer;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RESET_BAR = 1'b0;
    always #5 CLK = ~CLK;

    alu_sequencer_if bus();

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_bytes, stat_stalls;
`endif

    alu_sequencer #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RESET_BAR (RESET_BAR),
        .bus       (bus)
`ifdef ALU_SEQ_STATS_EN
        ,
        .STAT_BYTES  (stat_bytes),
        .STAT_STALLS (stat_stalls)
`endif
    );

    // Two-stage ALU as an adder: stage-1 inputs captured at each edge, stage 2
    // adds with carry chosen by CARRY_SEL (10 = its own carry from the previous cycle).
    logic [7:0] alu_s1_lhs, alu_s1_rhs;
    logic       alu_c_prev;
    logic       alu_cin;
    logic [8:0] alu_sum;
    always @(posedge CLK) begin
        alu_s1_lhs <= bus.ALU_LHS;
        alu_s1_rhs <= bus.ALU_RHS;
        alu_c_prev <= bus.ALU_CARRY_OUT;
    end
    always_comb begin
        alu_cin = 1'b0;
        case (bus.ALU_CARRY_SEL)
            2'b01:   alu_cin = 1'b1;
            2'b10:   alu_cin = alu_c_prev;
            default: alu_cin = 1'b0;
        endcase
        alu_sum = {1'b0, alu_s1_lhs} + {1'b0, alu_s1_rhs} + {8'd0, alu_cin};
    end
    assign bus.ALU_RESULT    = alu_sum[7:0];
    assign bus.ALU_CARRY_OUT = alu_sum[8];

    int         errors = 0;
    int         checks = 0;
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int         hs_q[$];
    logic [1:0] sel_log[$];
    logic       rv_log[$];
    int         stall_total = 0;
    int         stall_base = 0;
    bit         rnd_on = 1'b0;

    // Per-cycle monitor, sampling late in the cycle; log index = cycle number.
    always @(negedge CLK) begin
        #3;
        if (RESET_BAR) begin
            if (bus.REQ_VALID && bus.REQ_READY) hs_q.push_back(sel_log.size());
            if (bus.REQ_VALID && !bus.REQ_READY) stall_total <= stall_total + 1;
            if (bus.RSP_VALID && bus.RSP_READY) got_q.push_back({bus.RSP_LAST, bus.RSP_CARRY, bus.RSP_RESULT});
        end
        sel_log.push_back(bus.ALU_CARRY_SEL);
        rv_log.push_back(bus.RSP_VALID);
    end

    // Reference: a packet is one little-endian integer sum L + R + cin; byte i of the
    // response is that byte of the sum, its carry is the carry out of the low i+1 bytes.
    function automatic void model_packet(input logic [31:0] l, input logic [31:0] r, input int n, input logic cin);
        longint mask, part;
        for (int i = 0; i < n; i++) begin
            mask = (longint'(1) << (8 * (i + 1))) - 1;
            part = (longint'(l) & mask) + (longint'(r) & mask) + longint'(cin);
            exp_q.push_back({(i == n - 1), part[8 * (i + 1)], part[8 * i +: 8]});
        end
    endfunction

    task automatic drive_byte(input logic [7:0] l, input logic [7:0] r, input logic cin, input logic last,
                              input logic [1:0] sh, input logic [1:0] si, input logic [3:0] lo);
        int t = 0;
        bus.REQ_LHS = l;
        bus.REQ_RHS = r;
        bus.REQ_CIN = cin;
        bus.REQ_LAST = last;
        bus.REQ_SHIFT_OP = sh;
        bus.REQ_SHIFT_INTERP = si;
        bus.REQ_LOGIC_OP = lo;
        bus.REQ_VALID = 1'b1;
        while (!bus.REQ_READY) begin
            @(negedge CLK);
            t++;
            if (t > 300) begin
                $display("FAIL drive_timeout REQ_READY stuck low for %0d cycles, required high", t);
                $fatal(1, "request handshake never completed");
            end
        end
        @(negedge CLK);
        bus.REQ_VALID = 1'b0;
    endtask

    task automatic wait_rsp(input int n, output bit timed_out);
        int t = 0;
        timed_out = 1'b0;
        while (got_q.size() < n) begin
            @(negedge CLK);
            t++;
            if (t > 600) begin
                timed_out = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge CLK);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET_BAR = 1'b0;
        bus.REQ_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_BAR = 1'b1;
        stall_base = stall_total;
        got_q.delete();
        exp_q.delete();
        hs_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.ALU_LHS, bus.ALU_RHS, bus.ALU_SHIFT_OP, bus.ALU_SHIFT_INTERP, bus.ALU_LOGIC_OP} !== 24'h0) begin
            errors++;
            $display("FAIL reset_alu_outputs got=%h required=000000", {bus.ALU_LHS, bus.ALU_RHS, bus.ALU_SHIFT_OP, bus.ALU_SHIFT_INTERP, bus.ALU_LOGIC_OP});
        end
        checks++;
        if (bus.ALU_CARRY_SEL !== 2'b00) begin errors++; $display("FAIL reset_carry_sel got=%b required=00", bus.ALU_CARRY_SEL); end
        checks++;
        if (bus.RSP_VALID !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b required=0", bus.RSP_VALID); end
        checks++;
        if (bus.REQ_READY !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b required=1", bus.REQ_READY); end
`ifdef ALU_SEQ_STATS_EN
        checks++;
        if ({stat_bytes, stat_stalls} !== 32'h0) begin errors++; $display("FAIL reset_stats got=%h required=00000000", {stat_bytes, stat_stalls}); end
`endif
    endtask

    task automatic test_back_to_back();
        bit to;
        bus.RSP_READY = 1'b1;
        got_q.delete(); exp_q.delete(); hs_q.delete();
        model_packet(32'h12FF, 32'h0001, 2, 1'b0);
        drive_byte(8'hFF, 8'h01, 1'b0, 1'b0, 2'b00, 2'b00, 4'hA);
        checks++;
        if ({bus.ALU_LHS, bus.ALU_RHS, bus.ALU_SHIFT_OP, bus.ALU_SHIFT_INTERP, bus.ALU_LOGIC_OP} !== {8'hFF, 8'h01, 2'b00, 2'b00, 4'hA}) begin
            errors++;
            $display("FAIL b2b_s1_drive got=%h required=%h", {bus.ALU_LHS, bus.ALU_RHS, bus.ALU_SHIFT_OP, bus.ALU_SHIFT_INTERP, bus.ALU_LOGIC_OP}, {8'hFF, 8'h01, 2'b00, 2'b00, 4'hA});
        end
        drive_byte(8'h12, 8'h00, 1'b1, 1'b1, 2'b00, 2'b00, 4'hA);
        wait_rsp(2, to);
        checks++;
        if (hs_q.size() != 2 || hs_q[1] != hs_q[0] + 1) begin errors++; $display("FAIL b2b_issue_rate handshakes=%0d required 2 on consecutive cycles", hs_q.size()); end
        else begin
            checks++;
            if (sel_log[hs_q[0] + 2] !== 2'b00) begin errors++; $display("FAIL b2b_sel_byte0 got=%b required=00", sel_log[hs_q[0] + 2]); end
            checks++;
            if (sel_log[hs_q[1] + 2] !== 2'b10) begin errors++; $display("FAIL b2b_sel_byte1 got=%b required=10", sel_log[hs_q[1] + 2]); end
        end
        checks++;
        if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_rsp_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_rsp[%0d] got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : 10'h3FF, exp_q[i]); end
        end
    endtask

    task automatic test_bubble();
        bit to;
        bus.RSP_READY = 1'b1;
        got_q.delete(); exp_q.delete(); hs_q.delete();
        model_packet(32'h12FF, 32'h0001, 2, 1'b0);
        drive_byte(8'hFF, 8'h01, 1'b0, 1'b0, 2'b00, 2'b00, 4'hA);
        repeat (2) @(negedge CLK);
        checks++;
        if ({bus.ALU_LHS, bus.ALU_RHS} !== 16'hFF01) begin errors++; $display("FAIL bubble_hold got=%h required=ff01", {bus.ALU_LHS, bus.ALU_RHS}); end
        drive_byte(8'h12, 8'h00, 1'b0, 1'b1, 2'b00, 2'b00, 4'hA);
        wait_rsp(2, to);
        checks++;
        if (hs_q.size() != 2 || sel_log[hs_q[1] + 2] !== 2'b01) begin
            errors++;
            $display("FAIL bubble_sel_byte1 got=%b required=01", (hs_q.size() == 2) ? sel_log[hs_q[1] + 2] : 2'bxx);
        end
        checks++;
        if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL bubble_rsp_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bubble_rsp[%0d] got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : 10'h3FF, exp_q[i]); end
        end
    endtask

    task automatic test_single_latency();
        bit to;
        bus.RSP_READY = 1'b1;
        got_q.delete(); exp_q.delete(); hs_q.delete();
        model_packet(32'h00, 32'h00, 1, 1'b1);
        drive_byte(8'h00, 8'h00, 1'b1, 1'b1, 2'b01, 2'b10, 4'h5);
        wait_rsp(1, to);
        checks++;
        if (hs_q.size() != 1 || sel_log[hs_q[0] + 2] !== 2'b01) begin errors++; $display("FAIL single_sel got=%b required=01", (hs_q.size() == 1) ? sel_log[hs_q[0] + 2] : 2'bxx); end
        checks++;
        if (hs_q.size() != 1 || rv_log[hs_q[0] + 2] !== 1'b0 || rv_log[hs_q[0] + 3] !== 1'b1) begin
            errors++;
            $display("FAIL single_latency rsp_valid at +2/+3 got=%b%b required=01", (hs_q.size() == 1) ? rv_log[hs_q[0] + 2] : 1'bx, (hs_q.size() == 1) ? rv_log[hs_q[0] + 3] : 1'bx);
        end
        checks++;
        if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_rsp got=%h count=%0d required=%h", (got_q.size() > 0) ? got_q[0] : 10'h3FF, got_q.size(), exp_q[0]); end
    endtask

    task automatic test_reset_midpacket();
        bit to;
        bus.RSP_READY = 1'b1;
        got_q.delete(); exp_q.delete(); hs_q.delete();
        drive_byte(8'hFF, 8'h01, 1'b0, 1'b1, 2'b00, 2'b00, 4'hA);
        wait_rsp(1, to);
        bus.RSP_READY = 1'b0;
        drive_byte(8'h80, 8'h80, 1'b1, 1'b0, 2'b11, 2'b11, 4'hF);
        RESET_BAR = 1'b0;
        #1;
        checks++;
        if ({bus.ALU_LHS, bus.ALU_RHS, bus.ALU_SHIFT_OP, bus.ALU_SHIFT_INTERP, bus.ALU_LOGIC_OP, bus.ALU_CARRY_SEL} !== 26'h0) begin
            errors++;
            $display("FAIL midrst_alu_outputs got=%h required=0", {bus.ALU_LHS, bus.ALU_RHS, bus.ALU_SHIFT_OP, bus.ALU_SHIFT_INTERP, bus.ALU_LOGIC_OP, bus.ALU_CARRY_SEL});
        end
        @(negedge CLK);
        RESET_BAR = 1'b1;
        repeat (4) @(negedge CLK);
        checks++;
        if (bus.RSP_VALID !== 1'b0 || bus.REQ_READY !== 1'b1) begin errors++; $display("FAIL midrst_flushed rsp_valid=%b req_ready=%b required 0/1", bus.RSP_VALID, bus.REQ_READY); end
        got_q.delete(); exp_q.delete(); hs_q.delete();
        bus.RSP_READY = 1'b1;
        model_packet(32'h80, 32'h80, 1, 1'b0);
        drive_byte(8'h80, 8'h80, 1'b0, 1'b1, 2'b00, 2'b00, 4'hA);
        wait_rsp(1, to);
        checks++;
        if (hs_q.size() != 1 || sel_log[hs_q[0] + 2] !== 2'b00) begin errors++; $display("FAIL midrst_fresh_sel got=%b required=00", (hs_q.size() == 1) ? sel_log[hs_q[0] + 2] : 2'bxx); end
        checks++;
        if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL midrst_fresh_rsp got=%h count=%0d required=%h", (got_q.size() > 0) ? got_q[0] : 10'h3FF, got_q.size(), exp_q[0]); end
    endtask

    task automatic test_credit();
        logic [7:0] cl[6], cr[6];
        logic       ccin[6];
        int         acc = 0;
        int         t = 0;
        bit         take, to;
        apply_reset();
        bus.RSP_READY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cl[i] = 8'($urandom); cr[i] = 8'($urandom); ccin[i] = 1'($urandom_range(0, 1));
            model_packet({24'h0, cl[i]}, {24'h0, cr[i]}, 1, ccin[i]);
        end
        bus.REQ_LHS = cl[0]; bus.REQ_RHS = cr[0]; bus.REQ_CIN = ccin[0]; bus.REQ_LAST = 1'b1;
        bus.REQ_VALID = 1'b1;
        while (acc < 6 && t < 120) begin
            if (t == 12) begin
                checks++;
                if (acc != DEPTH) begin errors++; $display("FAIL credit_accepted got=%0d required=%0d", acc, DEPTH); end
                checks++;
                if (bus.REQ_READY !== 1'b0) begin errors++; $display("FAIL credit_ready got=%b required=0", bus.REQ_READY); end
                bus.RSP_READY = 1'b1;
            end
            take = bus.REQ_READY;
            @(negedge CLK);
            t++;
            if (take) begin
                acc++;
                if (acc < 6) begin
                    bus.REQ_LHS = cl[acc]; bus.REQ_RHS = cr[acc]; bus.REQ_CIN = ccin[acc];
                end else begin
                    bus.REQ_VALID = 1'b0;
                end
            end
        end
        bus.REQ_VALID = 1'b0;
        bus.RSP_READY = 1'b1;
        wait_rsp(6, to);
        checks++;
        if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL credit_rsp_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL credit_rsp[%0d] got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : 10'h3FF, exp_q[i]); end
        end
`ifdef ALU_SEQ_STATS_EN
        checks++;
        if (stat_bytes !== 16'd6) begin errors++; $display("FAIL stat_bytes got=%0d required=6", stat_bytes); end
        checks++;
        if (int'(stat_stalls) != stall_total - stall_base) begin errors++; $display("FAIL stat_stalls got=%0d required=%0d", stat_stalls, stall_total - stall_base); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] l, r;
        logic [1:0]  sh, si;
        logic [3:0]  lo;
        logic        cin;
        int          n;
        bit          to;
        got_q.delete(); exp_q.delete(); hs_q.delete();
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(negedge CLK);
                    bus.RSP_READY = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int p = 0; p < 20; p++) begin
            l = $urandom; r = $urandom; n = $urandom_range(1, 4); cin = 1'($urandom_range(0, 1));
            model_packet(l, r, n, cin);
            for (int i = 0; i < n; i++) begin
                sh = 2'($urandom); si = 2'($urandom); lo = 4'($urandom);
                drive_byte(l[8 * i +: 8], r[8 * i +: 8], cin, (i == n - 1), sh, si, lo);
                checks++;
                if ({bus.ALU_LHS, bus.ALU_RHS, bus.ALU_SHIFT_OP, bus.ALU_SHIFT_INTERP, bus.ALU_LOGIC_OP} !== {l[8 * i +: 8], r[8 * i +: 8], sh, si, lo}) begin
                    errors++;
                    $display("FAIL rand_s1_drive pkt=%0d byte=%0d got=%h required=%h", p, i, {bus.ALU_LHS, bus.ALU_RHS, bus.ALU_SHIFT_OP, bus.ALU_SHIFT_INTERP, bus.ALU_LOGIC_OP}, {l[8 * i +: 8], r[8 * i +: 8], sh, si, lo});
                end
                repeat ($urandom_range(0, 2)) @(negedge CLK);
            end
        end
        rnd_on = 1'b0;
        repeat (2) @(negedge CLK);
        bus.RSP_READY = 1'b1;
        wait_rsp(exp_q.size(), to);
        checks++;
        if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_rsp_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_rsp[%0d] got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : 10'h3FF, exp_q[i]); end
        end
    endtask

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_LHS = 8'h00;
        bus.REQ_RHS = 8'h00;
        bus.REQ_SHIFT_OP = 2'b00;
        bus.REQ_SHIFT_INTERP = 2'b00;
        bus.REQ_LOGIC_OP = 4'h0;
        bus.REQ_CIN = 1'b0;
        bus.REQ_LAST = 1'b0;
        bus.RSP_READY = 1'b0;
        test_reset();
        test_back_to_back();
        test_bubble();
        test_single_latency();
        test_reset_midpacket();
        test_credit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
